// File: rtl/ahb2regbus_ws.sv
// AHB-Lite slave to IP register-bus bridge: HSIZE byte enables, SEQ bursts, IP ready handshake with timeout.
// One address cycle then a data phase that stalls on ip_ready; illegal accesses and timeouts give a two-cycle ERROR.
module ahb2regbus_ws #(
   parameter int          ADDR_WIDTH     = 32,
   parameter int          DATA_WIDTH     = 32,
   parameter int          OFFSET_MSB     = 11,
   parameter int unsigned REG_START      = 'h000,
   parameter int unsigned REG_END        = 'h148,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    HSEL,
   input  logic [ADDR_WIDTH-1:0]   HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   input  logic [2:0]              HSIZE,
   input  logic [DATA_WIDTH-1:0]   HWDATA,
   input  logic                    HREADY,
   output logic                    HREADYOUT,
   output logic [1:0]              HRESP,
   output logic [DATA_WIDTH-1:0]   HRDATA,
   output logic                    ip_valid,
   output logic                    ip_wr1_rd0,
   output logic [ADDR_WIDTH-1:0]   ip_addr,
   output logic [DATA_WIDTH/8-1:0] ip_byte_en,
   output logic [DATA_WIDTH-1:0]   ip_write_data,
   input  logic [DATA_WIDTH-1:0]   ip_read_data,
   input  logic                    ip_ready
);

   localparam int NB     = DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(NB);
   localparam int OFF_W  = OFFSET_MSB + 1;
   localparam int CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [OFF_W-1:0] START_OFF = OFF_W'(REG_START);
   localparam logic [OFF_W-1:0] END_OFF   = OFF_W'(REG_END);
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;

   state_t                 state, state_n;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic                   wr_q;
   logic [NB-1:0]          be_q, be_d;
   logic [CNT_W-1:0]       cnt;
   logic                   load;

   logic [OFF_W-1:0]       offset;
   logic                   lo_ok, hi_ok, size_ok, align_ok, legal, addr_vld;
   logic                   unused_trans;

   assign unused_trans = HTRANS[0];
   assign offset       = HADDR[OFFSET_MSB:0];
   assign hi_ok        = offset <= END_OFF;
   assign size_ok      = HSIZE <= 3'(LANE_W);
   assign addr_vld     = HSEL && HREADY && HTRANS[1];
   assign legal        = lo_ok && hi_ok && size_ok && align_ok;

   generate
      if (REG_START == 0) begin : g_lo_zero
         assign lo_ok = 1'b1;
      end else begin : g_lo_cmp
         assign lo_ok = offset >= START_OFF;
      end
   endgenerate

   // Alignment and lane enables come straight from the low address bits and the size.
   always_comb begin
      align_ok = 1'b1;
      be_d     = '0;
      for (int i = 0; i < LANE_W; i++)
         if (HADDR[i] && (i < int'(HSIZE))) align_ok = 1'b0;
      for (int i = 0; i < NB; i++)
         if ((i >= int'(HADDR[LANE_W-1:0])) && (i < int'(HADDR[LANE_W-1:0]) + (1 << int'(HSIZE))))
            be_d[i] = 1'b1;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state  <= S_IDLE;
         addr_q <= '0;
         wr_q   <= 1'b0;
         be_q   <= '0;
         cnt    <= '0;
      end else begin
         state <= state_n;
         if (load) begin
            addr_q <= HADDR;
            wr_q   <= HWRITE;
            be_q   <= be_d;
            cnt    <= '0;
         end else if (state == S_ACCESS) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // An address phase is only sampled in cycles where this slave is completing (or idle).
   always_comb begin
      state_n = state;
      load    = 1'b0;
      case (state)
         S_IDLE, S_ERR2: begin
            if (addr_vld) begin
               state_n = legal ? S_ACCESS : S_ERR1;
               load    = legal;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (ip_ready) begin
               if (addr_vld) begin
                  state_n = legal ? S_ACCESS : S_ERR1;
                  load    = legal;
               end else begin
                  state_n = S_IDLE;
               end
            end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
               state_n = S_ERR1;
            end
         end
         S_ERR1:  state_n = S_ERR2;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT  = 1'b1;
      HRESP      = RESP_OKAY;
      HRDATA     = '0;
      ip_valid   = 1'b0;
      ip_wr1_rd0 = 1'b0;
      ip_addr    = '0;
      ip_byte_en = '0;
      case (state)
         S_ACCESS: begin
            HREADYOUT  = ip_ready;
            ip_valid   = 1'b1;
            ip_wr1_rd0 = wr_q;
            ip_addr    = addr_q;
            ip_byte_en = be_q;
            if (ip_ready && !wr_q) HRDATA = ip_read_data;
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = RESP_ERROR;
         end
         S_ERR2:  HRESP = RESP_ERROR;
         default: ;
      endcase
   end

   assign ip_write_data = HWDATA;

endmodule

// File: tb/tb_ahb2regbus_ws.sv
// Bench for ahb2regbus_ws: directed scenarios with a completion scoreboard on the IP side.
module tb_ahb2regbus_ws;

   localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;
   logic        ip_valid;
   logic        ip_wr1_rd0;
   logic [31:0] ip_addr;
   logic [3:0]  ip_byte_en;
   logic [31:0] ip_write_data;
   logic [31:0] ip_read_data;
   logic        ip_ready;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 HCLK = ~HCLK;

   // Single-slave interconnect: the bus ready is this slave's ready.
   assign HREADY = HREADYOUT;

   ahb2regbus_ws #(.TIMEOUT_CYCLES(4)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .ip_valid(ip_valid),
      .ip_wr1_rd0(ip_wr1_rd0), .ip_addr(ip_addr), .ip_byte_en(ip_byte_en),
      .ip_write_data(ip_write_data), .ip_read_data(ip_read_data), .ip_ready(ip_ready)
   );

   // Every completed IP access must match the oldest expected transfer.
   always @(negedge HCLK) begin
      if (!HRESET && ip_valid && ip_ready) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: completion at addr %h with empty scoreboard", ip_addr);
         end else begin
            e = sb.pop_front();
            if ({ip_addr, ip_wr1_rd0, ip_byte_en} !== {e.addr, e.wr, e.be}) begin
               failures++;
               $display("FAIL sb_cmd: got addr=%h wr=%b be=%h want addr=%h wr=%b be=%h",
                        ip_addr, ip_wr1_rd0, ip_byte_en, e.addr, e.wr, e.be);
            end
            if ((e.wr ? ip_write_data : HRDATA) !== e.data) begin
               failures++;
               $display("FAIL sb_data: got %h want %h", e.wr ? ip_write_data : HRDATA, e.data);
            end
         end
      end
   end

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [1:0] t);
      HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = s; HTRANS = t;
   endtask

   task automatic bus_idle();
      HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = '0; HTRANS = T_IDLE;
   endtask

   task automatic next_cyc();
      @(posedge HCLK); #1;
   endtask

   task automatic test_reset();
      @(negedge HCLK);
      checks++; if ({HREADYOUT, HRESP} !== 3'b100) begin failures++; $display("FAIL rst_resp: got rdy/resp %b want 100", {HREADYOUT, HRESP}); end
      checks++; if ({ip_valid, ip_wr1_rd0, ip_byte_en} !== 6'b0) begin failures++; $display("FAIL rst_ip: got vld/wr/be %b want 0", {ip_valid, ip_wr1_rd0, ip_byte_en}); end
      checks++; if ({ip_addr, HRDATA} !== 64'h0) begin failures++; $display("FAIL rst_data: got addr/rdata %h want 0", {ip_addr, HRDATA}); end
      HRESET = 1'b0;
      next_cyc();
   endtask

   task automatic test_write();
      ip_ready = 1'b1;
      addr_phase(32'h004, 1'b1, 3'd2, T_NONSEQ);
      sb.push_back('{32'h004, 1'b1, 4'hF, 32'hDEADBEEF});
      next_cyc();
      bus_idle(); HWDATA = 32'hDEADBEEF;
      @(negedge HCLK);
      checks++; if ({ip_valid, ip_byte_en} !== 5'b1_1111) begin failures++; $display("FAIL wr_vld_be: got %b want 11111", {ip_valid, ip_byte_en}); end
      checks++; if (ip_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data: got %h want deadbeef", ip_write_data); end
      checks++; if ({HREADYOUT, HRESP} !== 3'b100) begin failures++; $display("FAIL wr_resp: got %b want 100", {HREADYOUT, HRESP}); end
      next_cyc();
      @(negedge HCLK);
      checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL wr_idle: got ip_valid %b want 0", ip_valid); end
      next_cyc();
   endtask

   task automatic test_byte_read_wait();
      ip_ready = 1'b0;
      addr_phase(32'h013, 1'b0, 3'd0, T_NONSEQ);
      sb.push_back('{32'h013, 1'b0, 4'b1000, 32'h11223344});
      next_cyc();
      bus_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         checks++; if ({HREADYOUT, ip_valid, ip_byte_en} !== 6'b0_1_1000) begin failures++; $display("FAIL rd_wait%0d: got rdy/vld/be %b want 011000", i, {HREADYOUT, ip_valid, ip_byte_en}); end
         next_cyc();
      end
      ip_ready = 1'b1; ip_read_data = 32'h11223344;
      @(negedge HCLK);
      checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rd_done: got HREADYOUT %b want 1", HREADYOUT); end
      checks++; if (HRDATA !== 32'h11223344) begin failures++; $display("FAIL rd_data: got %h want 11223344", HRDATA); end
      next_cyc();
      ip_read_data = '0;
   endtask

   task automatic test_error();
      logic [31:0] addrs [2] = '{32'h14C, 32'h002};
      logic [2:0]  sizes [2] = '{3'd2, 3'd2};
      ip_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         addr_phase(addrs[k], 1'b0, sizes[k], T_NONSEQ);
         next_cyc();
         bus_idle();
         @(negedge HCLK);
         checks++; if ({HREADYOUT, HRESP, ip_valid} !== 4'b0_01_0) begin failures++; $display("FAIL err1_%0d: got rdy/resp/vld %b want 0010", k, {HREADYOUT, HRESP, ip_valid}); end
         next_cyc();
         @(negedge HCLK);
         checks++; if ({HREADYOUT, HRESP, ip_valid} !== 4'b1_01_0) begin failures++; $display("FAIL err2_%0d: got rdy/resp/vld %b want 1010", k, {HREADYOUT, HRESP, ip_valid}); end
         next_cyc();
         @(negedge HCLK);
         checks++; if ({HREADYOUT, HRESP} !== 3'b100) begin failures++; $display("FAIL err_end_%0d: got rdy/resp %b want 100", k, {HREADYOUT, HRESP}); end
      end
      next_cyc();
   endtask

   task automatic test_timeout();
      int vld_cnt = 0;
      ip_ready = 1'b0;
      addr_phase(32'h008, 1'b1, 3'd2, T_NONSEQ);
      next_cyc();
      bus_idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge HCLK);
         if (ip_valid === 1'b1) vld_cnt++;
         next_cyc();
      end
      checks++; if (vld_cnt != 4) begin failures++; $display("FAIL to_valid: got %0d valid cycles want 4", vld_cnt); end
      @(negedge HCLK);
      checks++; if ({HREADYOUT, HRESP, ip_valid} !== 4'b0_01_0) begin failures++; $display("FAIL to_err1: got rdy/resp/vld %b want 0010", {HREADYOUT, HRESP, ip_valid}); end
      next_cyc();
      @(negedge HCLK);
      checks++; if ({HREADYOUT, HRESP, ip_valid} !== 4'b1_01_0) begin failures++; $display("FAIL to_err2: got rdy/resp/vld %b want 1010", {HREADYOUT, HRESP, ip_valid}); end
      next_cyc();
      @(negedge HCLK);
      checks++; if ({HREADYOUT, HRESP, ip_valid} !== 4'b1_00_0) begin failures++; $display("FAIL to_idle: got rdy/resp/vld %b want 1000", {HREADYOUT, HRESP, ip_valid}); end
      next_cyc();
   endtask

   task automatic test_back_to_back();
      logic [31:0] wd [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
      ip_ready = 1'b1;
      addr_phase(32'h100, 1'b1, 3'd2, T_NONSEQ);
      sb.push_back('{32'h100, 1'b1, 4'hF, wd[0]});
      for (int k = 1; k <= 4; k++) begin
         next_cyc();
         HWDATA = wd[k-1];
         if (k < 4) begin
            addr_phase(32'h100 + 32'(4 * k), 1'b1, 3'd2, T_SEQ);
            sb.push_back('{32'h100 + 32'(4 * k), 1'b1, 4'hF, wd[k]});
         end else begin
            bus_idle();
         end
         @(negedge HCLK);
         checks++; if ({ip_valid, ip_addr} !== {1'b1, 32'h100 + 32'(4 * (k - 1))}) begin failures++; $display("FAIL burst_beat%0d: got vld/addr %b/%h want 1/%h", k, ip_valid, ip_addr, 32'h100 + 32'(4 * (k - 1))); end
      end
      next_cyc();
      @(negedge HCLK);
      checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL burst_end: got ip_valid %b want 0", ip_valid); end
      next_cyc();
   endtask

   task automatic test_reset_abort();
      ip_ready = 1'b0;
      addr_phase(32'h020, 1'b0, 3'd2, T_NONSEQ);
      next_cyc();
      bus_idle();
      @(negedge HCLK);
      checks++; if ({ip_valid, HREADYOUT} !== 2'b10) begin failures++; $display("FAIL abort_pre: got vld/rdy %b want 10", {ip_valid, HREADYOUT}); end
      #2 HRESET = 1'b1;
      #1;
      checks++; if ({ip_valid, HREADYOUT, HRESP} !== 4'b0_1_00) begin failures++; $display("FAIL abort_now: got vld/rdy/resp %b want 0100", {ip_valid, HREADYOUT, HRESP}); end
      @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0;
      next_cyc();
      ip_ready = 1'b1;
      addr_phase(32'h024, 1'b1, 3'd2, T_NONSEQ);
      sb.push_back('{32'h024, 1'b1, 4'hF, 32'h5A5A_1234});
      next_cyc();
      bus_idle(); HWDATA = 32'h5A5A_1234;
      @(negedge HCLK);
      checks++; if ({ip_valid, HREADYOUT, ip_addr} !== {2'b11, 32'h024}) begin failures++; $display("FAIL abort_post: got vld/rdy/addr %b/%h want 11/00000024", {ip_valid, HREADYOUT}, ip_addr); end
      next_cyc();
   endtask

   initial begin
      HRESET = 1'b1;
      bus_idle();
      HWDATA = '0; ip_read_data = '0; ip_ready = 1'b1;
      test_reset();
      test_write();
      test_byte_read_wait();
      test_error();
      test_timeout();
      test_back_to_back();
      test_reset_abort();
      repeat (2) next_cyc();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
